// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parameterised width and power-of-two depth.
// Provides occupancy, almost-full/empty, sticky error flags and an optional FWFT read port.
//
// Ports:
//   i_clk          rising-edge clock for all state
//   i_rst_n        asynchronous active-low reset (release synchronous to i_clk)
//   i_wr_en        write request
//   i_wr_data      write data
//   i_rd_en        read request (FWFT=1: pop the presented head word)
//   i_err_clr      synchronous clear of o_overflow / o_underflow
//   o_rd_data      read data
//   o_rd_valid     o_rd_data is valid
//   o_full         count == DEPTH
//   o_empty        count == 0
//   o_almost_full  count >= AF_LEVEL
//   o_almost_empty count <= AE_LEVEL
//   o_count        occupancy 0..DEPTH
//   o_overflow     sticky: a write was rejected
//   o_underflow    sticky: a read was rejected
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic                       i_err_clr,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds sized to the count so the compares stay width-matched.
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Storage: not reset, contents are don't-care until written.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    logic        ovf_q;
    logic        ovf_d;
    logic        unf_q;
    logic        unf_d;

    logic        empty;
    logic        full;
    logic        rd_acc;
    logic        wr_acc;
    logic [AW:0] count;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // ------------------------------------------------------------
    // Status, derived from the registered pointers only
    // ------------------------------------------------------------
    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_addr == rd_addr);

    assign o_count        = count;
    assign o_empty        = empty;
    assign o_full         = full;
    assign o_almost_full  = (count >= AF_LVL);
    assign o_almost_empty = (count <= AE_LVL);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

    // ------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------
    // A write into a full FIFO is still taken when a read frees the
    // head slot in the same cycle; a read from empty is never taken,
    // even alongside a write.
    assign rd_acc = i_rd_en & ~empty;
    assign wr_acc = i_wr_en & (~full | rd_acc);

    // ------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Set has priority over clear so no rejected access goes unseen.
    always_comb begin
        ovf_d = ovf_q & ~i_err_clr;
        unf_d = unf_q & ~i_err_clr;
        if (i_wr_en & ~wr_acc) begin
            ovf_d = 1'b1;
        end
        if (i_rd_en & ~rd_acc) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------
    if (FWFT) begin : g_fwft
        // Head word is always presented; i_rd_en only advances it.
        assign o_rd_data  = mem_q[rd_addr];
        assign o_rd_valid = ~empty;
    end else begin : g_reg
        logic [WIDTH-1:0] rd_data_q;
        logic [WIDTH-1:0] rd_data_d;
        logic             rd_valid_q;
        logic             rd_valid_d;

        // Data register holds its last value between reads.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) begin
                rd_data_d = mem_q[rd_addr];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign o_rd_data  = rd_data_q;
        assign o_rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read instance checked by a scoreboard,
// plus a first-word-fall-through instance checked with directed probes.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic [4:0] count;
    logic       ovf;
    logic       unf;

    logic       f_wr_en;
    logic [7:0] f_wr_data;
    logic       f_rd_en;
    logic       f_err_clr;
    logic [7:0] f_rd_data;
    logic       f_rd_valid;
    logic       f_full;
    logic       f_empty;
    logic       f_af;
    logic       f_ae;
    logic [4:0] f_count;
    logic       f_ovf;
    logic       f_unf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .i_rd_en       (rd_en),
        .i_err_clr     (err_clr),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (af),
        .o_almost_empty(ae),
        .o_count       (count),
        .o_overflow    (ovf),
        .o_underflow   (unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1)) dut_f (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (f_wr_en),
        .i_wr_data     (f_wr_data),
        .i_rd_en       (f_rd_en),
        .i_err_clr     (f_err_clr),
        .o_rd_data     (f_rd_data),
        .o_rd_valid    (f_rd_valid),
        .o_full        (f_full),
        .o_empty       (f_empty),
        .o_almost_full (f_af),
        .o_almost_empty(f_ae),
        .o_count       (f_count),
        .o_overflow    (f_ovf),
        .o_underflow   (f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read-valid pulse must match the next
    // expected word; a pulse with nothing expected is an error.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_valid: got unexpected pulse data %0h expected none",
                         rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    // One clock of stimulus; the reference queue decides what is
    // accepted and queues the expected read word.
    task automatic do_cyc(input logic w, input logic [7:0] d,
                          input logic r, input logic c);
        bit ra;
        bit wa;
        ra = r && (model.size() > 0);
        wa = w && (model.size() < 16 || ra);
        if (ra) exp_q.push_back(model.pop_front());
        if (wa) model.push_back(d);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        f_wr_en   = 1'b0;
        f_wr_data = 8'h00;
        f_rd_en   = 1'b0;
        f_err_clr = 1'b0;
        #1;

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ae", ae, 1);
        chk("rst_af", af, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        chk("rst_f_valid", f_rd_valid, 0);
        chk("rst_f_flags", {f_full, f_empty, f_af, f_ae, f_ovf, f_unf}, 6'b010100);
        chk("rst_f_count", f_count, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            do_cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_count", count, i + 1);
            chk("fill_af", af, (i + 1) >= 14);
            chk("fill_ae", ae, (i + 1) <= 2);
        end
        chk("fill_full", full, 1);
        chk("fill_ovf", ovf, 0);

        // 2: rejected write when full, then drain in order
        do_cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            do_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", empty, 1);
        do_cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("valid_pulse", rd_valid, 0);
        chk("data_hold", rd_data, 8'h0F);

        // 3: underflow, clear, set-beats-clear
        do_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", unf, 1);
        chk("unf_valid", rd_valid, 0);
        do_cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_set_wins", unf, 1);
        chk("ovf_clr_same", ovf, 0);
        do_cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", ovf, 0);
        chk("clr_unf", unf, 0);

        // 4: full with simultaneous read+write for 20 cycles
        for (int i = 0; i < 16; i++) begin
            do_cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        chk("rw_pre_full", full, 1);
        for (int i = 0; i < 20; i++) begin
            do_cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            chk("rw_count", count, 16);
            chk("rw_not_empty", empty, 0);
        end
        chk("rw_ovf", ovf, 0);
        for (int i = 0; i < 16; i++) begin
            do_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rw_drained", empty, 1);

        // Read+write on empty: only the write is taken
        do_cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("e_rw_count", count, 1);
        chk("e_rw_unf", unf, 1);
        do_cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("e_rw_empty", empty, 1);
        chk("e_rw_clr", unf, 0);

        // 5: first-word-fall-through instance
        f_wr_en   = 1'b1;
        f_wr_data = 8'h5C;
        #1;
        chk("f_pre_valid", f_rd_valid, 0);
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        chk("f_valid", f_rd_valid, 1);
        chk("f_data", f_rd_data, 8'h5C);
        chk("f_count", f_count, 1);
        f_wr_en   = 1'b1;
        f_wr_data = 8'hA1;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        chk("f_head_kept", f_rd_data, 8'h5C);
        f_rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("f_next_head", f_rd_data, 8'hA1);
        chk("f_valid2", f_rd_valid, 1);
        @(posedge clk);
        #1;
        f_rd_en = 1'b0;
        chk("f_empty", f_empty, 1);
        chk("f_valid_off", f_rd_valid, 0);
        chk("f_no_unf", f_unf, 0);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 10; i++) begin
            do_cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        do_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_count", count, 9);
        chk("pre_rst_valid", rd_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_count", count, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("sb_drained", exp_q.size(), 0);
        model.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Post-reset sanity: old contents are gone
        do_cyc(1'b1, 8'h99, 1'b0, 1'b0);
        do_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        do_cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_empty", empty, 1);
        chk("sb_final", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
